// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit/receive blocks: parity encodings,
// FSM state type and the bit-time divisor calculation.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  // Nearest-integer divisor so the bit time error stays under half a clock.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous-reset FIFO with occupancy count; shared by the UART TX and RX paths.
// Pushes when full and pops when empty are ignored.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (level == FULL_LVL);
  assign empty    = (level == '0);
  assign pop_data = mem[rd_ptr];

  // Pointers are exactly AW bits wide, so wrap modulo DEPTH is free.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_stream.sv
// Parametrised UART transmitter fed by a valid/ready queue; frames are sent
// back-to-back while tx_en is high and the queue holds data.
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [DATA_BITS-1:0]          s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic                          tx_en,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CW  = $clog2(CPB + 1);
  localparam int BW  = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(CPB - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY < PAR_NONE || PARITY > PAR_EVEN ||
      STOP_BITS < 1 || STOP_BITS > 2 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      BAUD <= 0 || CPB < 1) begin : g_bad_param
    $error("uart_tx_stream: illegal parameter combination");
  end

  tx_state_t            state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [BW-1:0]        idx, idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par, par_n;
  logic                 tx_n;
  logic                 pop;
  logic [DATA_BITS-1:0] head;
  logic                 full, empty;
  logic                 bit_end, can_start;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (s_valid),
    .push_data (s_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

  assign s_ready   = !full;
  assign busy      = (state != ST_IDLE) || (fifo_level != '0);
  assign bit_end   = (cnt == CNT_LAST);
  assign can_start = !empty && tx_en;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      par   <= 1'b0;
      tx    <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shreg <= shreg_n;
      par   <= par_n;
      tx    <= tx_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = idx;
    shreg_n = shreg;
    par_n   = par;
    pop     = 1'b0;
    tx_n    = 1'b1;

    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        if (can_start) begin
          pop     = 1'b1;
          state_n = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_n   = '0;
          shreg_n = shreg >> 1;
          idx_n   = idx + 1'b1;
          if (idx == DATA_LAST) begin
            idx_n   = '0;
            state_n = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          cnt_n = '0;
          idx_n = idx + 1'b1;
          if (idx == STOP_LAST) begin
            idx_n = '0;
            // Chain straight into the next start bit when more data waits.
            if (can_start) begin
              pop     = 1'b1;
              state_n = ST_START;
            end else begin
              state_n = ST_IDLE;
            end
          end
        end
      end
      default: begin
        cnt_n   = '0;
        idx_n   = '0;
        state_n = ST_IDLE;
      end
    endcase

    if (pop) begin
      shreg_n = head;
      par_n   = (PARITY == PAR_ODD) ? ~^head : ^head;
    end

    // Line level is a function of where the FSM lands, so tx is registered
    // and changes on the same edge as the state.
    case (state_n)
      ST_START:  tx_n = 1'b0;
      ST_DATA:   tx_n = shreg_n[0];
      ST_PARITY: tx_n = par_n;
      default:   tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Bench for uart_tx_stream: four configurations share one stimulus stream and
// are checked each cycle against a frame-level queue model, plus literal waveform points.
module tb_uart_tx_stream;

  localparam int CPB = 16;
  localparam int NI  = 4;
  localparam int HN  = 32768;
  localparam int DB [NI] = '{8, 8, 8, 7};
  localparam int PB [NI] = '{0, 2, 1, 0};
  localparam int SB [NI] = '{1, 1, 1, 2};
  localparam int DP [NI] = '{4, 16, 16, 16};

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       s_valid = 1'b0;
  logic       tx_en = 1'b0;
  logic [7:0] s_data = 8'h00;

  wire [NI-1:0] txs, bsy, rdy;
  wire [2:0]    lvl0;
  wire [4:0]    lvl1, lvl2, lvl3;

  always #5 clk = ~clk;

  uart_tx_stream #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rstn(rstn), .s_data(s_data), .s_valid(s_valid), .s_ready(rdy[0]),
    .tx_en(tx_en), .tx(txs[0]), .busy(bsy[0]), .fifo_level(lvl0));
  uart_tx_stream #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) u1 (
    .clk(clk), .rstn(rstn), .s_data(s_data), .s_valid(s_valid), .s_ready(rdy[1]),
    .tx_en(tx_en), .tx(txs[1]), .busy(bsy[1]), .fifo_level(lvl1));
  uart_tx_stream #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) u2 (
    .clk(clk), .rstn(rstn), .s_data(s_data), .s_valid(s_valid), .s_ready(rdy[2]),
    .tx_en(tx_en), .tx(txs[2]), .busy(bsy[2]), .fifo_level(lvl2));
  uart_tx_stream #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(16)) u3 (
    .clk(clk), .rstn(rstn), .s_data(s_data[6:0]), .s_valid(s_valid), .s_ready(rdy[3]),
    .tx_en(tx_en), .tx(txs[3]), .busy(bsy[3]), .fifo_level(lvl3));

  int          total = 0;
  int          bad = 0;
  int          mq [NI][$];
  logic [15:0] fb [NI];
  int          flen [NI];
  int          pos [NI];
  bit          act [NI];
  bit          armed = 1'b0;
  bit          hist_tx [NI][HN];
  bit          hist_bs [NI][HN];
  int          ncyc = 0;

  task automatic chk(input string nm, input int i, input int a, input int e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s u%0d: got %0d, want %0d (cycle %0d)", nm, i, a, e, ncyc);
    end
  endtask

  task automatic timeout_fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out at cycle %0d", nm, ncyc);
  endtask

  // Whole frame as a bit list: start, data LSB first, optional parity, stops.
  function automatic void build(input int i, input int w);
    logic [15:0] f;
    int n, ones;
    f = '1;
    f[0] = 1'b0;
    n = 1;
    ones = 0;
    for (int b = 0; b < DB[i]; b++) begin
      f[n] = ((w >> b) & 1) != 0;
      ones += (w >> b) & 1;
      n++;
    end
    if (PB[i] != 0) begin
      f[n] = (PB[i] == 2) ? ((ones % 2) == 1) : ((ones % 2) == 0);
      n++;
    end
    fb[i]   = f;
    flen[i] = n + SB[i];
    pos[i]  = 0;
    act[i]  = 1'b1;
  endfunction

  initial begin
    bit take;
    int w;
    forever begin
      @(posedge clk);
      for (int i = 0; i < NI; i++) begin
        if (!rstn) begin
          mq[i].delete();
          act[i] = 1'b0;
          pos[i] = 0;
        end else begin
          take = s_valid && (mq[i].size() < DP[i]);
          w = int'(s_data) & ((1 << DB[i]) - 1);
          if (act[i]) begin
            pos[i]++;
            if (pos[i] == flen[i] * CPB) act[i] = 1'b0;
          end
          if (!act[i] && tx_en && mq[i].size() > 0) build(i, mq[i].pop_front());
          if (take) mq[i].push_back(w);
        end
      end
      if (!rstn) armed = 1'b1;
    end
  end

  initial begin
    int lv [NI];
    int etx;
    forever begin
      @(negedge clk);
      lv[0] = int'(lvl0);
      lv[1] = int'(lvl1);
      lv[2] = int'(lvl2);
      lv[3] = int'(lvl3);
      for (int i = 0; i < NI; i++) begin
        if (ncyc < HN) begin
          hist_tx[i][ncyc] = txs[i];
          hist_bs[i][ncyc] = bsy[i];
        end
        if (armed) begin
          etx = act[i] ? int'(fb[i][pos[i] / CPB]) : 1;
          chk("m_tx", i, int'(txs[i]), etx);
          chk("m_busy", i, int'(bsy[i]), int'(act[i] || mq[i].size() > 0));
          chk("m_ready", i, int'(rdy[i]), int'(mq[i].size() < DP[i]));
          chk("m_level", i, lv[i], mq[i].size());
        end
      end
      ncyc++;
    end
  end

  function automatic int ht(input int i, input int k);
    if (k < 0 || k >= HN || k >= ncyc) return -1;
    return int'(hist_tx[i][k]);
  endfunction

  function automatic int hb(input int i, input int k);
    if (k < 0 || k >= HN || k >= ncyc) return -1;
    return int'(hist_bs[i][k]);
  endfunction

  function automatic int find_start(input int t);
    for (int k = (t < 0 ? 0 : t); k < ncyc && k < HN; k++)
      if (!hist_tx[0][k]) return k;
    return -1;
  endfunction

  task automatic push(input logic [7:0] d);
    s_data  = d;
    s_valid = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      if (rdy[0]) begin
        @(negedge clk);
        s_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    timeout_fail("push");
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 8000; k++) begin
      if (bsy == '0) begin
        repeat (2) @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    timeout_fail("wait_idle");
  endtask

  initial begin
    int t, s, zeros, g;
    rstn  = 1'b0;
    tx_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 0, int'(txs[0]), 1);
    chk("rst_busy", 0, int'(bsy[0]), 0);
    chk("rst_ready", 0, int'(rdy[0]), 1);
    chk("rst_level", 0, int'(lvl0), 0);
    rstn  = 1'b1;
    tx_en = 1'b1;
    @(negedge clk);

    // 8N1 0x55: alternating line, each level held exactly one bit time
    t = ncyc;
    push(8'h55);
    wait_idle();
    s = find_start(t);
    if (s < 0) timeout_fail("t1_start");
    else begin
      chk("t1_pre_idle", 0, ht(0, s - 1), 1);
      for (int b = 0; b < 10; b++) begin
        chk("t1_bit_first", 0, ht(0, s + b * CPB), b % 2);
        chk("t1_bit_last", 0, ht(0, s + b * CPB + CPB - 1), b % 2);
      end
      chk("t1_busy_end", 0, hb(0, s + 159), 1);
      chk("t1_busy_fall", 0, hb(0, s + 160), 0);
      chk("t1_idle_after", 0, ht(0, s + 160), 1);
    end

    // parity on 0x07: even -> 1, odd -> 0, frame 176 cycles
    t = ncyc;
    push(8'h07);
    wait_idle();
    s = find_start(t);
    if (s < 0) timeout_fail("t2_start");
    else begin
      chk("t2_even_par", 1, ht(1, s + 9 * CPB + 8), 1);
      chk("t2_odd_par", 2, ht(2, s + 9 * CPB + 8), 0);
      chk("t2_nopar_stop", 0, ht(0, s + 9 * CPB + 8), 1);
      chk("t2_busy_end", 1, hb(1, s + 175), 1);
      chk("t2_busy_fall", 1, hb(1, s + 176), 0);
    end

    // four bytes back-to-back, 640 cycles total
    t = ncyc;
    push(8'h41);
    push(8'h42);
    push(8'h43);
    push(8'h44);
    wait_idle();
    s = find_start(t);
    if (s < 0) timeout_fail("t3_start");
    else begin
      for (int k = 0; k < 4; k++) begin
        chk("t3_start_bit", 0, ht(0, s + k * 160 + 8), 0);
        chk("t3_lsb", 0, ht(0, s + k * 160 + 24), (k % 2 == 0) ? 1 : 0);
      end
      chk("t3_stop_tail", 0, ht(0, s + 159), 1);
      chk("t3_no_gap", 0, ht(0, s + 160), 0);
      chk("t3_byte3_bit6", 0, ht(0, s + 320 + 7 * CPB + 8), 1);
      chk("t3_busy_end", 0, hb(0, s + 639), 1);
      chk("t3_busy_fall", 0, hb(0, s + 640), 0);
    end

    // depth-4 queue fills with tx_en low; fifth word held until a pop
    tx_en = 1'b0;
    @(negedge clk);
    push(8'hA0);
    push(8'hA1);
    push(8'hA2);
    push(8'hA3);
    s_data  = 8'hA4;
    s_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("t4_level_full", 0, int'(lvl0), 4);
      chk("t4_ready_low", 0, int'(rdy[0]), 0);
      chk("t4_idle_line", 0, int'(txs[0]), 1);
    end
    tx_en = 1'b1;
    @(negedge clk);
    chk("t4_start_next_edge", 0, int'(txs[0]), 0);
    chk("t4_ready_after_pop", 0, int'(rdy[0]), 1);
    chk("t4_level_after_pop", 0, int'(lvl0), 3);
    @(negedge clk);
    s_valid = 1'b0;
    chk("t4_fifth_taken", 0, int'(lvl0), 4);
    wait_idle();

    // 7 data bits, 2 stop bits: next start at cycle 160
    t = ncyc;
    push(8'h7F);
    push(8'h7F);
    wait_idle();
    s = find_start(t);
    if (s < 0) timeout_fail("t5_start");
    else begin
      chk("t5_start", 3, ht(3, s + 8), 0);
      chk("t5_d0", 3, ht(3, s + 24), 1);
      chk("t5_d6", 3, ht(3, s + 120), 1);
      chk("t5_stop_first", 3, ht(3, s + 128), 1);
      chk("t5_stop_last", 3, ht(3, s + 159), 1);
      chk("t5_next_start", 3, ht(3, s + 160), 0);
      chk("t5_busy_end", 3, hb(3, s + 319), 1);
      chk("t5_busy_fall", 3, hb(3, s + 320), 0);
    end

    // reset mid-frame with two words queued
    t = ncyc;
    push(8'hB1);
    push(8'hB2);
    push(8'hB3);
    repeat (2) @(negedge clk);
    s = find_start(t);
    if (s < 0) timeout_fail("t6_start");
    else begin
      g = 0;
      while (ncyc < s + 3 * CPB + 4 && g < 1000) begin
        @(negedge clk);
        g++;
      end
      chk("t6_queued", 0, int'(lvl0), 2);
      rstn = 1'b0;
      @(negedge clk);
      chk("t6_tx_high", 0, int'(txs[0]), 1);
      chk("t6_level_zero", 0, int'(lvl0), 0);
      chk("t6_busy_low", 0, int'(bsy[0]), 0);
      rstn = 1'b1;
      t = ncyc;
      repeat (300) @(negedge clk);
      zeros = 0;
      for (int k = t; k < ncyc && k < HN; k++) if (!hist_tx[0][k]) zeros++;
      chk("t6_no_frames", 0, zeros, 0);
    end

    // randomized traffic, tx_en toggling and occasional resets
    for (int c = 0; c < 2500; c++) begin
      s_valid = ($urandom_range(0, 5) == 0);
      s_data  = 8'($urandom);
      if ($urandom_range(0, 80) == 0) tx_en = !tx_en;
      rstn = ($urandom_range(0, 1500) != 0);
      @(negedge clk);
    end
    s_valid = 1'b0;
    rstn    = 1'b1;
    tx_en   = 1'b1;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
